// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and the write-request record used by the register-file write front end.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the primary writeback, secondary handshake and regfile write port of the arbiter.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
);

  logic                  p_we;
  logic [REG_ADDR_W-1:0] p_addr;
  logic [XLEN-1:0]       p_wd;
  logic                  s_valid;
  logic                  s_ready;
  logic [REG_ADDR_W-1:0] s_addr;
  logic [XLEN-1:0]       s_wd;
  logic                  we3;
  logic [REG_ADDR_W-1:0] a3;
  logic [XLEN-1:0]       wd3;
  logic [NUM_REGS-1:0]   pending;
  logic [CW-1:0]         fifo_count;

  modport master (
    output p_we, p_addr, p_wd, s_valid, s_addr, s_wd,
    input  s_ready, we3, a3, wd3, pending, fifo_count
  );

  modport slave (
    input  p_we, p_addr, p_wd, s_valid, s_addr, s_wd,
    output s_ready, we3, a3, wd3, pending, fifo_count
  );

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// Small FIFO of secondary results; entries can be invalidated in place by address match.
module wb_squash_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [REG_ADDR_W-1:0] push_addr_i,
  input  logic [XLEN-1:0]       push_data_i,
  input  logic                  pop_i,
  input  logic                  squash_i,
  input  logic [REG_ADDR_W-1:0] squash_addr_i,
  output wb_req_t               head_o,
  output logic [CW-1:0]         count_o,
  output logic                  full_o,
  output logic [NUM_REGS-1:0]   pending_o
);

  wb_req_t       entry_q [DEPTH];
  wb_req_t       entry_d [DEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;

  // The we bit of each entry doubles as its valid flag; squash and pop both clear it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (squash_i && entry_q[i].we && (entry_q[i].addr == squash_addr_i)) begin
        entry_d[i].we = 1'b0;
      end
    end
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    if (pop_i) begin
      entry_d[rdPtr_q].we = 1'b0;
      rdPtr_d = rdPtr_q + PW'(1);
    end
    if (push_i) begin
      entry_d[wrPtr_q] = '{we: 1'b1, addr: push_addr_i, data: push_data_i};
      wrPtr_d = wrPtr_q + PW'(1);
    end
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_q[i].we) begin
        pending_o[entry_q[i].addr] = 1'b1;
      end
    end
    pending_o[0] = 1'b0;
  end

  assign head_o  = entry_q[rdPtr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-side front end of the register file: primary writeback wins, queued secondary
// results fill idle write slots, and a younger primary write squashes older queued ones.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wb_arbiter_if.slave   bus
);

  wb_req_t       head;
  wb_req_t       wrSel;
  logic [CW-1:0] count;
  logic          full;
  logic          primWr;
  logic          fifoWr;
  logic          pop;
  logic          push;

  wb_squash_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_addr_i  (bus.s_addr),
    .push_data_i  (bus.s_wd),
    .pop_i        (pop),
    .squash_i     (primWr),
    .squash_addr_i(bus.p_addr),
    .head_o       (head),
    .count_o      (count),
    .full_o       (full),
    .pending_o    (bus.pending)
  );

  // A squashed head is popped even under a primary write; a valid head waits its turn.
  always_comb begin
    primWr = bus.p_we && (bus.p_addr != '0);
    fifoWr = !primWr && head.we && (count != '0);
    pop    = (count != '0) && (!head.we || !primWr);
    push   = bus.s_valid && !full && (bus.s_addr != '0) &&
             !(primWr && (bus.s_addr == bus.p_addr));
    wrSel  = '0;
    if (primWr) begin
      wrSel = '{we: 1'b1, addr: bus.p_addr, data: bus.p_wd};
    end else if (fifoWr) begin
      wrSel = head;
    end
  end

  assign bus.we3        = rst_n && wrSel.we;
  assign bus.a3         = wrSel.addr;
  assign bus.wd3        = wrSel.data;
  assign bus.s_ready    = !full;
  assign bus.fifo_count = count;

  a_single_write : assert property (@(posedge clk) disable iff (!rst_n) !(primWr && fifoWr));
  a_no_x0_write  : assert property (@(posedge clk) disable iff (!rst_n) bus.we3 |-> (bus.a3 != '0));
  a_s_stable     : assert property (@(posedge clk) disable iff (!rst_n)
                     (bus.s_valid && !bus.s_ready) |=>
                     (bus.s_valid && $stable(bus.s_addr) && $stable(bus.s_wd)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for the register-file write arbiter.
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;

  regfile_wb_arbiter_if #(.DEPTH(4)) bus ();

  regfile_wb_arbiter #(.DEPTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic pWe, input logic [4:0] pAddr, input logic [31:0] pWd,
                               input logic sValid, input logic [4:0] sAddr,
                               input logic [31:0] sWd);
    bus.p_we    = pWe;
    bus.p_addr  = pAddr;
    bus.p_wd    = pWd;
    bus.s_valid = sValid;
    bus.s_addr  = sAddr;
    bus.s_wd    = sWd;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    applyStimulus(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'h0);
    checkOutput("reset_we3", 64'(bus.we3), 64'd0);
    checkOutput("reset_s_ready", 64'(bus.s_ready), 64'd1);
    checkOutput("reset_count", 64'(bus.fifo_count), 64'd0);
    checkOutput("reset_pending", 64'(bus.pending), 64'd0);
    nextCycle();
    rst_n = 1'b1;

    applyStimulus(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0);
    checkOutput("prim_we3", 64'(bus.we3), 64'd1);
    checkOutput("prim_a3", 64'(bus.a3), 64'd5);
    checkOutput("prim_wd3", 64'(bus.wd3), 64'hA5A5A5A5);
    checkOutput("prim_s_ready", 64'(bus.s_ready), 64'd1);
    nextCycle();

    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h11);
    checkOutput("sec_enq_we3", 64'(bus.we3), 64'd0);
    checkOutput("sec_enq_pending", 64'(bus.pending), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("sec_wr_we3", 64'(bus.we3), 64'd1);
    checkOutput("sec_wr_a3", 64'(bus.a3), 64'd7);
    checkOutput("sec_wr_wd3", 64'(bus.wd3), 64'h11);
    checkOutput("sec_pending7", 64'(bus.pending), 64'h80);
    nextCycle();
    checkOutput("sec_after_pending", 64'(bus.pending), 64'd0);
    checkOutput("sec_after_count", 64'(bus.fifo_count), 64'd0);
    checkOutput("sec_after_we3", 64'(bus.we3), 64'd0);

    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 5'd10, 32'h1010, 1'b1, 5'(k), 32'h100 + 32'(k));
      checkOutput("fill_a3", 64'(bus.a3), 64'd10);
      nextCycle();
    end
    applyStimulus(1'b1, 5'd10, 32'h1010, 1'b0, 5'd0, 32'h0);
    checkOutput("full_count", 64'(bus.fifo_count), 64'd4);
    checkOutput("full_s_ready", 64'(bus.s_ready), 64'd0);
    checkOutput("full_pending", 64'(bus.pending), 64'h1E);
    nextCycle();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("drain_we3", 64'(bus.we3), 64'd1);
      checkOutput("drain_a3", 64'(bus.a3), 64'(k));
      checkOutput("drain_wd3", 64'(bus.wd3), 64'h100 + 64'(k));
      nextCycle();
    end
    checkOutput("drain_count", 64'(bus.fifo_count), 64'd0);
    checkOutput("drain_we3_idle", 64'(bus.we3), 64'd0);

    applyStimulus(1'b1, 5'd10, 32'h1010, 1'b1, 5'd3, 32'h33);
    nextCycle();
    applyStimulus(1'b1, 5'd10, 32'h1010, 1'b1, 5'd4, 32'h44);
    nextCycle();
    applyStimulus(1'b1, 5'd3, 32'h99, 1'b0, 5'd0, 32'h0);
    checkOutput("waw_a3", 64'(bus.a3), 64'd3);
    checkOutput("waw_wd3", 64'(bus.wd3), 64'h99);
    checkOutput("waw_pending_before", 64'(bus.pending), 64'h18);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("waw_squash_we3", 64'(bus.we3), 64'd0);
    checkOutput("waw_squash_pending", 64'(bus.pending), 64'h10);
    checkOutput("waw_squash_count", 64'(bus.fifo_count), 64'd2);
    nextCycle();
    checkOutput("waw_r4_a3", 64'(bus.a3), 64'd4);
    checkOutput("waw_r4_wd3", 64'(bus.wd3), 64'h44);
    nextCycle();
    checkOutput("waw_done_we3", 64'(bus.we3), 64'd0);
    checkOutput("waw_done_count", 64'(bus.fifo_count), 64'd0);

    applyStimulus(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h77);
    checkOutput("waw_same_a3", 64'(bus.a3), 64'd6);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("waw_same_count", 64'(bus.fifo_count), 64'd0);
    checkOutput("waw_same_we3", 64'(bus.we3), 64'd0);

    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h22);
    nextCycle();
    applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'h55);
    checkOutput("x0_we3", 64'(bus.we3), 64'd1);
    checkOutput("x0_a3", 64'(bus.a3), 64'd2);
    checkOutput("x0_wd3", 64'(bus.wd3), 64'h22);
    checkOutput("x0_s_ready", 64'(bus.s_ready), 64'd1);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("x0_count", 64'(bus.fifo_count), 64'd0);
    checkOutput("x0_pending", 64'(bus.pending), 64'd0);

    for (int k = 11; k <= 13; k++) begin
      applyStimulus(1'b1, 5'd10, 32'h1010, 1'b1, 5'(k), 32'(k));
      nextCycle();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("rst_pre_count", 64'(bus.fifo_count), 64'd3);
    checkOutput("rst_pre_a3", 64'(bus.a3), 64'd11);
    checkOutput("rst_pre_we3", 64'(bus.we3), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_we3", 64'(bus.we3), 64'd0);
    checkOutput("rst_mid_count", 64'(bus.fifo_count), 64'd0);
    nextCycle();
    rst_n = 1'b1;
    #1;
    checkOutput("rst_after_count", 64'(bus.fifo_count), 64'd0);
    checkOutput("rst_after_pending", 64'(bus.pending), 64'd0);
    checkOutput("rst_after_we3", 64'(bus.we3), 64'd0);
    nextCycle();
    #1;
    checkOutput("rst_after2_we3", 64'(bus.we3), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
